// File: rtl/tpu_mm_core.sv
// tpu_mm_core: streaming N x N matrix-multiply engine.
// Loads A then B element-wise, runs N MAC steps, then drains C row-major.
module tpu_mm_core #(
    parameter int N      = 2,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 18,
    parameter bit SIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              accumulate,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_last,
    output logic              busy
);

    localparam int NN = N * N;
    localparam int CW = $clog2(2 * NN);
    localparam int OW = $clog2(NN);
    localparam int KW = $clog2(N);

    localparam logic [CW-1:0] LAST_IN  = CW'(2 * NN - 1);
    localparam logic [OW-1:0] LAST_OUT = OW'(NN - 1);
    localparam logic [KW-1:0] LAST_K   = KW'(N - 1);

    typedef enum logic [1:0] {
        S_LOAD,
        S_COMPUTE,
        S_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]     in_cnt;
    logic [KW-1:0]     k_cnt;
    logic [OW-1:0]     out_idx;
    logic [DATA_W-1:0] op_m [2*NN];
    logic [ACC_W-1:0]  c_m  [NN];
    logic              in_fire;
    logic              out_fire;

    // Low half of the widened product is exact for both signednesses.
    function automatic logic [ACC_W-1:0] mul_ext(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [2*DATA_W-1:0] ea;
        logic [2*DATA_W-1:0] eb;
        logic [2*DATA_W-1:0] p;
        if (SIGNED) begin
            ea = {{DATA_W{a[DATA_W-1]}}, a};
            eb = {{DATA_W{b[DATA_W-1]}}, b};
        end else begin
            ea = {{DATA_W{1'b0}}, a};
            eb = {{DATA_W{1'b0}}, b};
        end
        p = ea * eb;
        if (SIGNED) begin
            return ACC_W'($signed(p));
        end else begin
            return ACC_W'(p);
        end
    endfunction

    assign in_ready  = !rst && (state_q == S_LOAD);
    assign out_valid = !rst && (state_q == S_DRAIN);
    assign busy      = !rst && (state_q == S_COMPUTE || state_q == S_DRAIN);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign out_last  = out_valid && (out_idx == LAST_OUT);
    assign out_data  = out_valid ? c_m[out_idx] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LOAD: begin
                if (in_fire && in_cnt == LAST_IN) state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                if (k_cnt == LAST_K) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (out_fire && out_idx == LAST_OUT) state_d = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            in_cnt  <= '0;
            k_cnt   <= '0;
            out_idx <= '0;
            for (int i = 0; i < 2 * NN; i++) op_m[i] <= '0;
            for (int i = 0; i < NN; i++) c_m[i] <= '0;
        end else begin
            if (in_fire) begin
                op_m[in_cnt] <= in_data;
                in_cnt <= (in_cnt == LAST_IN) ? '0 : in_cnt + 1'b1;
                if (in_cnt == '0 && !accumulate) begin
                    for (int i = 0; i < NN; i++) c_m[i] <= '0;
                end
            end
            if (state_q == S_COMPUTE) begin
                k_cnt <= (k_cnt == LAST_K) ? '0 : k_cnt + 1'b1;
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        c_m[i*N+j] <= c_m[i*N+j] + mul_ext(
                            op_m[i*N+int'(k_cnt)],
                            op_m[NN+int'(k_cnt)*N+j]);
                    end
                end
            end
            if (out_fire) begin
                out_idx <= (out_idx == LAST_OUT) ? '0 : out_idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tpu_mm_core.sv
// Bench for tpu_mm_core: three configurations, vector table plus
// scoreboard-checked drains and hand-written reset / scale-up sequences.
module tb_tpu_mm_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        accumulate;
    logic [7:0]  in_data;
    logic [2:0]  iv, ordy, ir, ov, ol, bsy;
    logic [17:0] od0, od2;
    logic [15:0] od1;
    logic [17:0] cur_od;
    int          sel;

    always_comb begin
        case (sel)
            0:       cur_od = od0;
            1:       cur_od = {2'b00, od1};
            default: cur_od = od2;
        endcase
    end

    tpu_mm_core #(.N(2), .DATA_W(8), .ACC_W(18), .SIGNED(1'b1)) u_s2 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_data(in_data), .accumulate(accumulate), .out_valid(ov[0]),
        .out_ready(ordy[0]), .out_data(od0), .out_last(ol[0]), .busy(bsy[0]));

    tpu_mm_core #(.N(2), .DATA_W(8), .ACC_W(16), .SIGNED(1'b0)) u_u2 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_data(in_data), .accumulate(accumulate), .out_valid(ov[1]),
        .out_ready(ordy[1]), .out_data(od1), .out_last(ol[1]), .busy(bsy[1]));

    tpu_mm_core #(.N(4), .DATA_W(8), .ACC_W(18), .SIGNED(1'b0)) u_u4 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_data(in_data), .accumulate(accumulate), .out_valid(ov[2]),
        .out_ready(ordy[2]), .out_data(od2), .out_last(ol[2]), .busy(bsy[2]));

    typedef struct {
        int sel;
        bit acc;
        bit gaps;
        int el[8];
        int ex[4];
    } vec_t;

    typedef struct {
        logic [17:0] data;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    bit   pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, req);
        end
    endtask

    task automatic load_batch(input int s, input bit acc, input int el[$],
                              input int ex[$], input bit gaps);
        int          idx;
        int          cyc;
        bit          gap;
        logic [17:0] mask;
        exp_t        e;
        sel  = s;
        mask = (s == 1) ? 18'h0FFFF : 18'h3FFFF;
        foreach (ex[i]) begin
            e.data = 18'(ex[i]) & mask;
            e.last = (i == ex.size() - 1);
            sb.push_back(e);
        end
        idx = 0;
        cyc = 0;
        while (idx < el.size() && cyc < 500) begin
            @(negedge clk);
            cyc++;
            gap        = gaps && ($urandom_range(0, 2) == 0);
            iv[s]      = !gap;
            in_data    = gap ? 8'($urandom) : 8'(el[idx]);
            accumulate = (idx == 0) ? acc : 1'($urandom);
            if (!gap && ir[s]) idx++;
        end
        @(negedge clk);
        iv[s] = 1'b0;
        if (idx < el.size()) check("load_timeout", idx, el.size());
    endtask

    task automatic drain_batch(input int n, input bit bp);
        int          lat;
        int          cyc;
        int          pi;
        bit          r;
        bit          held;
        logic [17:0] hv;
        exp_t        e;
        @(negedge clk);
        lat = 1;
        check("busy_compute", bsy[sel], 1);
        check("in_ready_compute", ir[sel], 0);
        iv[sel] = 1'b1;
        in_data = 8'hAA;
        while (!ov[sel] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        iv[sel] = 1'b0;
        check("latency", lat, n);
        pi   = 0;
        cyc  = 0;
        held = 1'b0;
        hv   = '0;
        while (sb.size() > 0 && cyc < 200) begin
            if (!ov[sel]) begin
                check("drain_valid", ov[sel], 1);
                sb.delete();
                break;
            end
            r = bp ? pat[pi % 7] : 1'b1;
            pi++;
            if (held) check("stall_hold", cur_od, hv);
            ordy[sel] = r;
            if (r) begin
                e = sb.pop_front();
                check("data", cur_od, e.data);
                check("last", ol[sel], e.last);
                held = 1'b0;
            end else begin
                hv   = cur_od;
                held = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        ordy[sel] = 1'b0;
        if (sb.size() != 0) begin
            check("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        check("done_valid", ov[sel], 0);
        check("done_ready", ir[sel], 1);
        check("done_busy", bsy[sel], 0);
    endtask

    vec_t tbl[6];
    int   el_q[$];
    int   ex_q[$];

    initial begin
        tbl[0] = '{1, 1'b0, 1'b0, '{1, 2, 3, 4, 5, 6, 7, 8}, '{19, 22, 43, 50}};
        tbl[1] = '{1, 1'b1, 1'b0, '{1, 2, 3, 4, 5, 6, 7, 8}, '{38, 44, 86, 100}};
        tbl[2] = '{1, 1'b0, 1'b0, '{1, 2, 3, 4, 5, 6, 7, 8}, '{19, 22, 43, 50}};
        tbl[3] = '{0, 1'b0, 1'b0, '{-1, 2, 3, -4, 5, 6, 7, 8}, '{9, 10, -13, -14}};
        tbl[4] = '{1, 1'b0, 1'b0, '{255, 255, 255, 255, 255, 255, 255, 255},
                   '{64514, 64514, 64514, 64514}};
        tbl[5] = '{0, 1'b0, 1'b1, '{1, 2, 3, 4, 5, 6, 7, 8}, '{19, 22, 43, 50}};

        rst        = 1'b1;
        iv         = '0;
        ordy       = '0;
        in_data    = '0;
        accumulate = 1'b0;
        sel        = 0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", ir, 3'b000);
        check("rst_out_valid", ov, 3'b000);
        check("rst_out_last", ol, 3'b000);
        check("rst_busy", bsy, 3'b000);
        check("rst_od0", od0, 0);
        check("rst_od1", od1, 0);
        check("rst_od2", od2, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", ir, 3'b111);

        for (int t = 0; t < 6; t++) begin
            el_q.delete();
            ex_q.delete();
            foreach (tbl[t].el[i]) el_q.push_back(tbl[t].el[i]);
            foreach (tbl[t].ex[i]) ex_q.push_back(tbl[t].ex[i]);
            load_batch(tbl[t].sel, tbl[t].acc, el_q, ex_q, tbl[t].gaps);
            drain_batch(2, tbl[t].gaps);
        end

        // Abort at k=1; accumulate=1 afterwards exposes any stale C.
        el_q.delete();
        ex_q.delete();
        foreach (tbl[0].el[i]) el_q.push_back(tbl[0].el[i]);
        load_batch(1, 1'b0, el_q, ex_q, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", bsy[1], 0);
        check("abort_valid", ov[1], 0);
        check("abort_ready", ir[1], 0);
        check("abort_data", od1, 0);
        rst = 1'b0;
        @(negedge clk);
        foreach (tbl[0].ex[i]) ex_q.push_back(tbl[0].ex[i]);
        load_batch(1, 1'b1, el_q, ex_q, 1'b0);
        drain_batch(2, 1'b0);

        el_q.delete();
        ex_q.delete();
        for (int i = 0; i < 16; i++) el_q.push_back((i / 4 == i % 4) ? 1 : 0);
        for (int i = 0; i < 16; i++) el_q.push_back(i + 1);
        for (int i = 0; i < 16; i++) ex_q.push_back(i + 1);
        load_batch(2, 1'b0, el_q, ex_q, 1'b0);
        drain_batch(4, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
